// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Mode encoding, divisor clamp rule and default counter width.
package clkdiv_pkg;

   localparam int CNT_W_DEF = 32;
   localparam int CNT_W_MAX = 64;

   typedef enum logic {
      MODE_TOGGLE = 1'b0,
      MODE_PULSE  = 1'b1
   } mode_e;

   // A zero divisor has no meaningful period; treat it as divide-by-one.
   function automatic logic [CNT_W_MAX-1:0] clamp_div(
      input logic [CNT_W_MAX-1:0] i_d
   );
      return (i_d == '0) ? CNT_W_MAX'(1) : i_d;
   endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, shadow config, apply logic, outputs.
// CLKDIV_SYNC_EN adds i_sync, a forced restart of the channel.
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int DIV_RESET = 50000000
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_div,
   input  logic             i_mode,
`ifdef CLKDIV_SYNC_EN
   input  logic             i_sync,
`endif
   output logic             o_clk,
   output logic             o_tick,
   output logic             o_pending
);

   localparam logic [CNT_W-1:0] LP_DIV_RST =
      CNT_W'(clamp_div(CNT_W_MAX'(DIV_RESET)));

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div;
   logic [CNT_W-1:0] r_pdiv;
   mode_e            r_mode;
   mode_e            r_pmode;
   logic             r_pend;
   logic             r_clk;
   logic             r_tick;

   logic w_wrap;
   logic w_sync;
   logic w_restart;
   logic w_apply;

`ifdef CLKDIV_SYNC_EN
   assign w_sync = i_sync;
`else
   assign w_sync = 1'b0;
`endif

   assign w_wrap    = (r_cnt == r_div - CNT_W'(1));
   assign w_restart = ~i_en | w_sync;
   // Shadow lands only on a period boundary or while the channel is idle.
   assign w_apply   = r_pend & (w_restart | w_wrap);

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_pend  <= 1'b0;
         r_pdiv  <= LP_DIV_RST;
         r_pmode <= MODE_TOGGLE;
         r_div   <= LP_DIV_RST;
         r_mode  <= MODE_TOGGLE;
      end else if (w_apply) begin
         r_div  <= r_pdiv;
         r_mode <= r_pmode;
         r_pend <= 1'b0;
      end else if (i_load) begin
         r_pend  <= 1'b1;
         r_pdiv  <= CNT_W'(clamp_div(CNT_W_MAX'(i_div)));
         r_pmode <= mode_e'(i_mode);
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_clk  <= 1'b0;
         r_tick <= 1'b0;
      end else if (w_restart) begin
         r_cnt  <= '0;
         r_clk  <= 1'b0;
         r_tick <= 1'b0;
      end else if (w_wrap) begin
         r_cnt  <= '0;
         r_tick <= 1'b1;
         r_clk  <= (r_mode == MODE_PULSE) ? 1'b1 : ~r_clk;
      end else begin
         r_cnt  <= r_cnt + CNT_W'(1);
         r_tick <= 1'b0;
         if (r_mode == MODE_PULSE) begin
            r_clk <= 1'b0;
         end
      end
   end

   assign o_clk     = r_clk;
   assign o_tick    = r_tick;
   assign o_pending = r_pend;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider and tick generator.
// Define CLKDIV_SYNC_EN to add the global phase-align input `sync`.
module prog_clock_divider
   import clkdiv_pkg::*;
#(
   parameter  int NUM_CH    = 4,
   parameter  int CNT_W     = CNT_W_DEF,
   parameter  int DIV_RESET = 50000000,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic [NUM_CH-1:0] enable,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_mode,
`ifdef CLKDIV_SYNC_EN
   input  logic              sync,
`endif
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   logic [NUM_CH-1:0]      w_pend;
   logic [NUM_CH-1:0]      w_load;
   logic [(1<<CH_W)-1:0]   w_pend_ext;
   logic                   w_acc;

   // Unpopulated channel slots never hold anything, so they always accept.
   always_comb begin
      w_pend_ext              = '0;
      w_pend_ext[NUM_CH-1:0]  = w_pend;
   end

   assign cfg_ready = ~w_pend_ext[cfg_ch];
   assign w_acc     = cfg_valid & cfg_ready;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_load[g] = w_acc & (cfg_ch == CH_W'(g));

      clkdiv_channel #(
         .CNT_W     (CNT_W),
         .DIV_RESET (DIV_RESET)
      ) u_ch (
         .clk_in    (clk_in),
         .reset     (reset),
         .i_en      (enable[g]),
         .i_load    (w_load[g]),
         .i_div     (cfg_div),
         .i_mode    (cfg_mode),
`ifdef CLKDIV_SYNC_EN
         .i_sync    (sync),
`endif
         .o_clk     (clk_out[g]),
         .o_tick    (tick[g]),
         .o_pending (w_pend[g])
      );
   end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider: expected samples queued by cycle.
// Sync scenario is included when CLKDIV_SYNC_EN is defined.
module tb_prog_clock_divider;

   localparam int NUM_CH  = 3;
   localparam int CNT_W   = 32;
   localparam int DIV_RST = 6;
   localparam int CH_W    = 2;

   logic              clk_in = 1'b0;
   logic              reset;
   logic [NUM_CH-1:0] enable;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic              cfg_mode;
`ifdef CLKDIV_SYNC_EN
   logic              sync;
`endif
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   prog_clock_divider #(
      .NUM_CH    (NUM_CH),
      .CNT_W     (CNT_W),
      .DIV_RESET (DIV_RST)
   ) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .enable    (enable),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_mode  (cfg_mode),
`ifdef CLKDIV_SYNC_EN
      .sync      (sync),
`endif
      .clk_out   (clk_out),
      .tick      (tick)
   );

   typedef struct {
      int                cyc;
      logic [NUM_CH-1:0] mask;
      logic [NUM_CH-1:0] clk;
      logic [NUM_CH-1:0] tick;
      bit                chk_rdy;
      bit                rdy;
      bit [95:0]         name;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   flush = 1'b0;

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   function automatic void push(exp_t e);
      int idx;
      idx = sb.size();
      while (idx > 0 && sb[idx-1].cyc > e.cyc) idx--;
      sb.insert(idx, e);
   endfunction

   function automatic void push_pat(int c0, int ch, string cs,
                                    string ts, bit [95:0] nm);
      for (int i = 0; i < cs.len(); i++) begin
         exp_t e;
         e.cyc      = c0 + i;
         e.mask     = '0;
         e.clk      = '0;
         e.tick     = '0;
         e.mask[ch] = 1'b1;
         e.clk[ch]  = (cs[i] == "1");
         e.tick[ch] = (ts[i] == "1");
         e.chk_rdy  = 1'b0;
         e.rdy      = 1'b0;
         e.name     = nm;
         push(e);
      end
   endfunction

   function automatic void push_zero_all(int c, bit [95:0] nm);
      exp_t e;
      e.cyc     = c;
      e.mask    = '1;
      e.clk     = '0;
      e.tick    = '0;
      e.chk_rdy = 1'b1;
      e.rdy     = 1'b1;
      e.name    = nm;
      push(e);
   endfunction

   function automatic void push_rdy(int c, bit r, bit [95:0] nm);
      exp_t e;
      e.cyc     = c;
      e.mask    = '0;
      e.clk     = '0;
      e.tick    = '0;
      e.chk_rdy = 1'b1;
      e.rdy     = r;
      e.name    = nm;
      push(e);
   endfunction

   // Monitor: pops every sample due this cycle and compares.
   always @(negedge clk_in) begin
      exp_t e;
      while (sb.size() > 0 && (flush || sb[0].cyc <= cyc)) begin
         e = sb.pop_front();
         if (e.cyc != cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %0s cyc=%0d: sample not taken (now cyc=%0d)",
                     e.name, e.cyc, cyc);
         end else begin
            if (e.mask != '0) begin
               n_cmp++;
               if (((clk_out & e.mask) !== e.clk) ||
                   ((tick & e.mask) !== e.tick)) begin
                  n_bad++;
                  $display("FAIL %0s cyc=%0d clk_out=%b tick=%b required clk_out=%b tick=%b (mask %b)",
                           e.name, cyc, clk_out & e.mask, tick & e.mask,
                           e.clk, e.tick, e.mask);
               end
            end
            if (e.chk_rdy) begin
               n_cmp++;
               if (cfg_ready !== e.rdy) begin
                  n_bad++;
                  $display("FAIL %0s cyc=%0d cfg_ready=%b required %b",
                           e.name, cyc, cfg_ready, e.rdy);
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic cfg_write(input int ch, input int d, input bit m);
      cfg_valid = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_div   = CNT_W'(d);
      cfg_mode  = m;
      step(1);
      cfg_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, c, s, a, b;
`ifdef CLKDIV_SYNC_EN
      int d, e;
`endif
      reset     = 1'b1;
      enable    = '0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      cfg_mode  = 1'b0;
`ifdef CLKDIV_SYNC_EN
      sync      = 1'b0;
`endif
      repeat (3) @(posedge clk_in);
      #1;
      reset = 1'b0;
      t = cyc;
      push_zero_all(t, "reset");
      push_zero_all(t + 1, "reset");

      // Program all three channels while disabled.
      step(2);
      c = cyc;
      push_rdy(c, 1'b1, "rdy_idle");
      push_rdy(c + 1, 1'b0, "rdy_pend");
      push_rdy(c + 2, 1'b1, "rdy_applied");
      cfg_write(0, 4, 1'b0);
      step(2);
      cfg_write(1, 3, 1'b1);
      cfg_write(2, 10, 1'b0);
      step(2);

      // Run: ch0 toggle D=4, ch1 pulse D=3, ch2 toggle D=10 -> D=2.
      s = cyc;
      push_pat(s + 1, 0, "0001111000011110", "0001000100010001", "ch0_d4");
      push_pat(s + 1, 1, "001001001", "001001001", "ch1_pulse3");
      push_pat(s + 1, 2, "000000000110011001100000110",
               "000000000101010101010000101", "ch2_retune");
      push_rdy(s + 5, 1'b1, "ch2_rdy");
      for (int i = 6; i <= 9; i++) push_rdy(s + i, 1'b0, "ch2_busy");
      push_rdy(s + 10, 1'b1, "ch2_rdy_wrap");
      push_rdy(s + 16, 1'b1, "rdy_oob");
      push_rdy(s + 17, 1'b1, "oob_nochg");
      push_rdy(s + 18, 1'b1, "oob_nochg");
      enable = '1;
      step(5);
      cfg_valid = 1'b1;
      cfg_ch    = 2'd2;
      cfg_div   = 32'd2;
      cfg_mode  = 1'b0;
      step(1);
      cfg_div = 32'd7;
      step(3);
      cfg_valid = 1'b0;
      step(7);
      cfg_valid = 1'b1;
      cfg_ch    = 2'd3;
      cfg_div   = 32'd5;
      step(1);
      cfg_valid = 1'b0;
      cfg_ch    = 2'd2;
      step(4);
      enable[2] = 1'b0;
      step(2);
      enable[2] = 1'b1;
      step(4);

      // ch1: pulse D=1, then cfg_div=0 in toggle mode.
      a = cyc;
      push_pat(a + 1, 1, "00", "00", "ch1_off");
      push_pat(a + 3, 1, "111111", "111111", "ch1_pulse1");
      push_pat(a + 9, 1, "00", "00", "ch1_off");
      push_pat(a + 11, 1, "101010", "111111", "ch1_div0");
      enable[1] = 1'b0;
      cfg_write(1, 1, 1'b1);
      step(1);
      enable[1] = 1'b1;
      step(6);
      enable[1] = 1'b0;
      cfg_write(1, 0, 1'b0);
      step(1);
      enable[1] = 1'b1;
      step(6);

      // Reset mid-period with a pending update on ch0.
      b = cyc;
      push_pat(b + 2, 0, "00011", "00010", "ch0_restart");
      push_rdy(b + 6, 1'b0, "ch0_pend");
      push_zero_all(b + 7, "async_rst");
      push_rdy(b + 8, 1'b1, "rst_rdy");
      push_pat(b + 8, 0, "0000001111110", "0000001000001", "ch0_divrst");
      enable[0] = 1'b0;
      step(1);
      enable[0] = 1'b1;
      step(4);
      cfg_write(0, 2, 1'b1);
      step(1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(13);

`ifdef CLKDIV_SYNC_EN
      // Phase-align ch0 (D=3) and ch1 (D=5) with a sync pulse.
      d = cyc;
      enable[1:0] = 2'b00;
      cfg_write(0, 3, 1'b1);
      cfg_write(1, 5, 1'b1);
      step(1);
      enable[0] = 1'b1;
      step(1);
      enable[1] = 1'b1;
      step(5);
      e = cyc;
      push_pat(e + 1, 0, "0001001001001001", "0001001001001001", "sync_ch0");
      push_pat(e + 1, 1, "0000010000100001", "0000010000100001", "sync_ch1");
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      step(16);
      if (d < 0) $display("cycle %0d", d);
`endif

      for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk_in);
      flush = 1'b1;
      @(negedge clk_in);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
